// File: rtl/wb_write_buffer.sv
// In-order write-back buffer between MEM/WB and the register-file write port.
// Queues results, drains one per cycle, and forwards queued data to two ID lookups.
module wb_write_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_wreg,
   input  logic [4:0]       in_waddr,
   input  logic [31:0]      in_wdata,
   input  logic             wb_stall,
   input  logic             flush,
   output logic             we,
   output logic [4:0]       waddr,
   output logic [31:0]      wdata,
   input  logic [4:0]       raddr1,
   output logic             hit1,
   output logic [31:0]      hdata1,
   input  logic [4:0]       raddr2,
   output logic             hit2,
   output logic [31:0]      hdata2,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [4:0]       addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count_q;
   logic             push;

   assign count    = count_q;
   assign in_ready = (count_q != FULL_CNT);

   // Filtered transfers (no register write, or $0) complete the handshake but store nothing.
   assign push = in_valid & in_ready & in_wreg & (in_waddr != 5'd0) & ~flush;

   assign we    = (count_q != '0) & ~wb_stall & ~flush;
   assign waddr = we ? addr_q[rd_ptr] : 5'd0;
   assign wdata = we ? data_q[rd_ptr] : 32'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         vld_q   <= '0;
      end else if (flush) begin
         count_q <= '0;
         rd_ptr  <= wr_ptr;
         vld_q   <= '0;
      end else begin
         if (we) begin
            rd_ptr        <= rd_ptr + 1'b1;
            vld_q[rd_ptr] <= 1'b0;
         end
         if (push) begin
            wr_ptr        <= wr_ptr + 1'b1;
            vld_q[wr_ptr] <= 1'b1;
         end
         case ({push, we})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage needs no reset; it is only observed through the valid bits and count.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= in_waddr;
         data_q[wr_ptr] <= in_wdata;
      end
   end

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx    = '0;
      hit1   = 1'b0;
      hdata1 = 32'd0;
      hit2   = 1'b0;
      hdata2 = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PTR_W'(i);
         if (vld_q[idx] && (raddr1 != 5'd0) && (addr_q[idx] == raddr1)) begin
            hit1   = 1'b1;
            hdata1 = data_q[idx];
         end
         if (vld_q[idx] && (raddr2 != 5'd0) && (addr_q[idx] == raddr2)) begin
            hit2   = 1'b1;
            hdata2 = data_q[idx];
         end
      end
   end

endmodule

// File: tb/tb_wb_write_buffer.sv
// Self-checking bench for wb_write_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of the buffer contents.
module tb_wb_write_buffer;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_wreg;
   logic [4:0]  in_waddr;
   logic [31:0] in_wdata;
   logic        wb_stall, flush;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr1, raddr2;
   logic        hit1, hit2;
   logic [31:0] hdata1, hdata2;
   logic [PTR_W:0] count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t mq[$];
   ent_t retired[$];
   ent_t sent[$];

   always #5 clk = ~clk;

   wb_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_wreg(in_wreg),
      .in_waddr(in_waddr), .in_wdata(in_wdata),
      .wb_stall(wb_stall), .flush(flush),
      .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .hit1(hit1), .hdata1(hdata1),
      .raddr2(raddr2), .hit2(hit2), .hdata2(hdata2),
      .count(count)
   );

   function automatic bit m_hit(input logic [4:0] r);
      bit h = 0;
      if (r != 5'd0) foreach (mq[i]) if (mq[i].a == r) h = 1;
      return h;
   endfunction

   function automatic logic [31:0] m_hdata(input logic [4:0] r);
      logic [31:0] d = 32'd0;
      if (r != 5'd0) foreach (mq[i]) if (mq[i].a == r) d = mq[i].d;
      return d;
   endfunction

   // Advance one clock edge and apply the same edge to the model queue.
   task automatic tick();
      bit w, ok;
      ent_t e;
      w  = (mq.size() != 0) && !wb_stall && !flush;
      ok = in_valid && (mq.size() != DEPTH) && in_wreg && (in_waddr != 5'd0);
      if (we) begin
         e.a = waddr; e.d = wdata;
         retired.push_back(e);
      end
      @(posedge clk);
      if (flush) mq.delete();
      else begin
         if (w) void'(mq.pop_front());
         if (ok) begin
            e.a = in_waddr; e.d = in_wdata;
            mq.push_back(e);
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_wreg = 0; in_waddr = 0; in_wdata = 0;
      wb_stall = 0; flush = 0; raddr1 = 0; raddr2 = 0;
   endtask

   task automatic drive(input logic [4:0] a, input logic [31:0] d);
      in_valid = 1; in_wreg = 1; in_waddr = a; in_wdata = d;
   endtask

   task automatic test_reset();
      rst = 1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (count !== 0 || we !== 0 || hit1 !== 0 || hit2 !== 0 || in_ready !== 1 || waddr !== 0 || wdata !== 0 || hdata1 !== 0 || hdata2 !== 0)
         begin errors++; $display("FAIL reset_state: count=%0d we=%0b hit1=%0b hit2=%0b in_ready=%0b, required 0,0,0,0,1", count, we, hit1, hit2, in_ready); end
      rst = 0;
      mq.delete();
      #1;
      wb_stall = 1;
      for (int i = 0; i < 3; i++) begin drive(5'(10 + i), 32'h100 + i); tick(); end
      in_valid = 0; raddr1 = 5'd11; #1;
      checks++; if (count !== 3 || hit1 !== 1)
         begin errors++; $display("FAIL reset_prefill: count=%0d hit1=%0b, required 3,1", count, hit1); end
      wb_stall = 0; #1;
      rst = 1; #1;
      checks++; if (we !== 0 || count !== 0 || hit1 !== 0)
         begin errors++; $display("FAIL reset_midstream: we=%0b count=%0d hit1=%0b, required 0,0,0", we, count, hit1); end
      mq.delete();
      @(posedge clk); #1;
      checks++; if (we !== 0)
         begin errors++; $display("FAIL reset_hold_we: we=%0b, required 0", we); end
      rst = 0; raddr1 = 0; #1;
      checks++; if (in_ready !== 1 || count !== 0)
         begin errors++; $display("FAIL reset_release: in_ready=%0b count=%0d, required 1,0", in_ready, count); end
   endtask

   task automatic test_single();
      idle_inputs();
      drive(5'd5, 32'hDEADBEEF);
      tick();
      in_valid = 0; #1;
      checks++; if (we !== 1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF)
         begin errors++; $display("FAIL single_write: we=%0b waddr=%0d wdata=%h, required 1,5,deadbeef", we, waddr, wdata); end
      tick(); #1;
      checks++; if (count !== 0 || we !== 0)
         begin errors++; $display("FAIL single_after: count=%0d we=%0b, required 0,0", count, we); end
   endtask

   task automatic test_full();
      idle_inputs();
      wb_stall = 1;
      for (int i = 1; i <= 5; i++) begin
         drive(5'(i), 32'hA000 + i); #1;
         checks++; if (in_ready !== (i <= 4))
            begin errors++; $display("FAIL full_ready_%0d: in_ready=%0b, required %0b", i, in_ready, (i <= 4)); end
         tick();
      end
      in_valid = 0; #1;
      checks++; if (count !== 4 || in_ready !== 0)
         begin errors++; $display("FAIL full_count: count=%0d in_ready=%0b, required 4,0", count, in_ready); end
      wb_stall = 0;
      for (int i = 1; i <= 4; i++) begin
         #1;
         checks++; if (we !== 1 || waddr !== 5'(i) || wdata !== 32'hA000 + i)
            begin errors++; $display("FAIL full_drain_%0d: we=%0b waddr=%0d wdata=%h, required 1,%0d,%h", i, we, waddr, wdata, i, 32'hA000 + i); end
         tick();
      end
      #1;
      checks++; if (count !== 0 || we !== 0)
         begin errors++; $display("FAIL full_empty: count=%0d we=%0b, required 0,0", count, we); end
   endtask

   task automatic test_forwarding();
      idle_inputs();
      wb_stall = 1;
      drive(5'd7, 32'h11); tick();
      drive(5'd7, 32'h22); tick();
      in_valid = 0; raddr1 = 5'd7; raddr2 = 5'd0; #1;
      checks++; if (hit1 !== 1 || hdata1 !== 32'h22)
         begin errors++; $display("FAIL fwd_port1: hit1=%0b hdata1=%h, required 1,22", hit1, hdata1); end
      checks++; if (hit2 !== 0 || hdata2 !== 0)
         begin errors++; $display("FAIL fwd_port2_zero: hit2=%0b hdata2=%h, required 0,0", hit2, hdata2); end
      raddr2 = 5'd8; drive(5'd8, 32'h33); #1;
      checks++; if (hit2 !== 0)
         begin errors++; $display("FAIL fwd_incoming: hit2=%0b, required 0", hit2); end
      in_valid = 0;
      flush = 1; tick(); flush = 0; #1;
      checks++; if (count !== 0 || hit1 !== 0)
         begin errors++; $display("FAIL fwd_flush: count=%0d hit1=%0b, required 0,0", count, hit1); end
   endtask

   task automatic test_filter_flush();
      idle_inputs();
      wb_stall = 1;
      drive(5'd0, 32'hFF); tick();
      drive(5'd3, 32'hEE); in_wreg = 0; tick();
      in_valid = 0; #1;
      checks++; if (count !== 0)
         begin errors++; $display("FAIL filter_count: count=%0d, required 0", count); end
      drive(5'd4, 32'h44); tick();
      drive(5'd6, 32'h66); tick();
      wb_stall = 0;
      drive(5'd9, 32'h99); flush = 1; #1;
      checks++; if (we !== 0 || in_ready !== 1)
         begin errors++; $display("FAIL flush_we: we=%0b in_ready=%0b, required 0,1", we, in_ready); end
      tick();
      flush = 0; in_valid = 0; #1;
      checks++; if (count !== 0 || we !== 0)
         begin errors++; $display("FAIL flush_count: count=%0d we=%0b, required 0,0", count, we); end
   endtask

   task automatic test_back_to_back();
      ent_t e;
      int k;
      idle_inputs();
      retired.delete(); sent.delete();
      for (int i = 0; i < 10; i++) begin
         e.a = 5'($urandom_range(1, 31)); e.d = $urandom;
         sent.push_back(e);
         drive(e.a, e.d);
         tick();
         checks++; if (count > 1)
            begin errors++; $display("FAIL b2b_count_%0d: count=%0d, required <=1", i, count); end
      end
      in_valid = 0;
      k = 0;
      while (count != 0 && k < 20) begin tick(); k++; end
      checks++; if (retired.size() != sent.size())
         begin errors++; $display("FAIL b2b_retire_count: retired=%0d, required %0d", retired.size(), sent.size()); end
      for (int i = 0; i < sent.size() && i < retired.size(); i++) begin
         checks++; if (retired[i].a !== sent[i].a || retired[i].d !== sent[i].d)
            begin errors++; $display("FAIL b2b_order_%0d: %0d/%h, required %0d/%h", i, retired[i].a, retired[i].d, sent[i].a, sent[i].d); end
      end
   endtask

   task automatic test_random();
      logic [4:0] ea;
      logic [31:0] ed;
      idle_inputs();
      for (int c = 0; c < 400; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_wreg  = ($urandom_range(0, 7) != 0);
         in_waddr = 5'($urandom_range(0, 7));
         in_wdata = $urandom;
         wb_stall = ($urandom_range(0, 9) < 4);
         flush    = ($urandom_range(0, 29) == 0);
         raddr1   = 5'($urandom_range(0, 7));
         raddr2   = 5'($urandom_range(0, 7));
         #1;
         ea = 0; ed = 0;
         if (mq.size() != 0 && !wb_stall && !flush) begin ea = mq[0].a; ed = mq[0].d; end
         checks++; if (we !== (mq.size() != 0 && !wb_stall && !flush) || waddr !== ea || wdata !== ed)
            begin errors++; $display("FAIL rnd_drain_%0d: we=%0b waddr=%0d wdata=%h, required waddr=%0d wdata=%h", c, we, waddr, wdata, ea, ed); end
         checks++; if (in_ready !== (mq.size() != DEPTH) || count !== mq.size())
            begin errors++; $display("FAIL rnd_occ_%0d: in_ready=%0b count=%0d, required count=%0d", c, in_ready, count, mq.size()); end
         checks++; if (hit1 !== m_hit(raddr1) || hdata1 !== m_hdata(raddr1) || hit2 !== m_hit(raddr2) || hdata2 !== m_hdata(raddr2))
            begin errors++; $display("FAIL rnd_lookup_%0d: hit1=%0b hdata1=%h hit2=%0b hdata2=%h, required %0b %h %0b %h", c, hit1, hdata1, hit2, hdata2, m_hit(raddr1), m_hdata(raddr1), m_hit(raddr2), m_hdata(raddr2)); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_forwarding();
      test_filter_flush();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
